// File: rtl/video_pattern_gen.sv
// video_pattern_gen: programmable video timing generator with ramp, colour-bar, solid and coordinate patterns.
module video_pattern_gen #(
  parameter int PIXEL_WIDTH = 10,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic [1:0]               pattern_i,
  input  logic [3*PIXEL_WIDTH-1:0] color_i,
  output logic [3*PIXEL_WIDTH-1:0] do_o,
  output logic                     de_o,
  output logic                     hs_o,
  output logic                     vs_o,
  output logic                     sof_o,
  output logic                     busy_o
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW = $clog2(BAR_W) + 1;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t                   r_state, w_next;
  logic [HW-1:0]            r_h;
  logic [VW-1:0]            r_v;
  logic [PIXEL_WIDTH-1:0]   r_frame;
  logic [BW-1:0]            r_bx;
  logic [2:0]               r_bar;
  logic [1:0]               r_pat;
  logic [3*PIXEL_WIDTH-1:0] r_col, w_pix;
  logic [PIXEL_WIDTH-1:0]   w_hp, w_vp;
  logic                     w_run, w_hlast, w_last, w_cap, w_de, w_hs, w_vs, w_sof;

  always_comb begin
    w_run   = r_state != IDLE;
    w_hlast = r_h == H_LAST;
    w_last  = w_hlast && r_v == V_LAST;
    w_next  = !w_run ? (en_i ? RUN : IDLE) : en_i ? RUN : w_last ? IDLE : STOP;
    // pattern/colour are latched so that they are valid while the counters sit at h=0,v=0
    w_cap   = en_i && (!w_run || w_last);
    w_de    = w_run && r_h < H_ACT && r_v < V_ACT;
    w_hs    = w_run && r_h >= HS_BEG && r_h < HS_END;
    w_vs    = w_run && r_v >= VS_BEG && r_v < VS_END;
    w_sof   = w_run && r_h == '0 && r_v == '0;
    w_hp    = PIXEL_WIDTH'(r_h);
    w_vp    = PIXEL_WIDTH'(r_v);
    w_pix   = r_pat == 2'd0 ? {3{w_hp}} :
              r_pat == 2'd1 ? {{PIXEL_WIDTH{~r_bar[0]}}, {PIXEL_WIDTH{~r_bar[2]}}, {PIXEL_WIDTH{~r_bar[1]}}} :
              r_pat == 2'd2 ? r_col : {r_frame, w_vp, w_hp};
    busy_o  = w_run;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_h     <= '0;
      r_v     <= '0;
      r_frame <= '0;
      r_bx    <= '0;
      r_bar   <= '0;
      r_pat   <= '0;
      r_col   <= '0;
      do_o    <= '0;
      de_o    <= 1'b0;
      hs_o    <= 1'b0;
      vs_o    <= 1'b0;
      sof_o   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_run) begin
        r_h <= w_hlast ? '0 : r_h + 1'b1;
        if (w_hlast) r_v <= w_last ? '0 : r_v + 1'b1;
        if (w_last) r_frame <= r_frame + 1'b1;
        r_bx  <= (w_hlast || r_bx == BAR_LAST) ? '0 : r_h < H_ACT ? r_bx + 1'b1 : r_bx;
        r_bar <= w_hlast ? '0 : (r_h < H_ACT && r_bx == BAR_LAST) ? r_bar + 1'b1 : r_bar;
      end
      if (w_cap) begin
        r_pat <= pattern_i;
        r_col <= color_i;
      end
      do_o  <= w_de ? w_pix : '0;
      de_o  <= w_de;
      hs_o  <= w_hs;
      vs_o  <= w_vs;
      sof_o <= w_sof;
    end
  end
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: scoreboard bench for video_pattern_gen on a small 24x7 raster (168 clk frame).
module tb_video_pattern_gen;
  localparam int PW = 10, HA = 16, HFP = 2, HSW = 3, HBP = 3, VA = 4, VFP = 1, VSW = 1, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP, VT = VA + VFP + VSW + VBP, FRAME = HT * VT;
  localparam logic [23:0] BARS = {3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111};

  typedef struct {
    int h; int v;
    logic [3*PW-1:0] d;
    logic de, hs, vs, sof, busy;
  } item_t;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [1:0] pat = '0;
  logic [3*PW-1:0] col = '0, dout;
  logic de, hs, vs, sof, busy;
  int chk = 0, npass = 0;
  int m_st, m_h, m_v, m_fr, m_pat;
  logic [3*PW-1:0] m_col;
  item_t q[$];

  always #5 clk = ~clk;

  video_pattern_gen #(.PIXEL_WIDTH(PW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
                      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)) dut (
    .clk(clk), .rst(rst), .en_i(en), .pattern_i(pat), .color_i(col),
    .do_o(dout), .de_o(de), .hs_o(hs), .vs_o(vs), .sof_o(sof), .busy_o(busy));

  function automatic logic [3*PW-1:0] f_pix(int p, int h, int v, int fr, logic [3*PW-1:0] c);
    logic [2:0] rgb;
    logic [PW-1:0] mx;
    mx = '1;
    rgb = BARS[(h / (HA / 8)) * 3 +: 3];
    case (p)
      0: return {3{PW'(h)}};
      1: return {rgb[0] ? mx : '0, rgb[1] ? mx : '0, rgb[2] ? mx : '0};
      2: return c;
      default: return {PW'(fr), PW'(v), PW'(h)};
    endcase
  endfunction

  function automatic logic [3*PW+4:0] act();
    return {dout, de, hs, vs, sof, busy};
  endfunction

  function automatic logic [3*PW+4:0] exp_of(item_t it);
    return {it.d, it.de, it.hs, it.vs, it.sof, it.busy};
  endfunction

  task automatic reset_model();
    m_st = 0; m_h = 0; m_v = 0; m_fr = 0; m_pat = 0; m_col = '0;
    q.delete();
  endtask

  // pushes the expectation for the current raster position, clocks once, pops what the DUT now shows
  task automatic tick(output item_t it);
    item_t e;
    int nst;
    bit run, last, cap;
    run = m_st != 0;
    last = m_h == HT - 1 && m_v == VT - 1;
    e.h = m_h; e.v = m_v;
    e.de = run && m_h < HA && m_v < VA;
    e.hs = run && m_h >= HA + HFP && m_h < HA + HFP + HSW;
    e.vs = run && m_v >= VA + VFP && m_v < VA + VFP + VSW;
    e.sof = run && m_h == 0 && m_v == 0;
    e.d = e.de ? f_pix(m_pat, m_h, m_v, m_fr, m_col) : '0;
    e.busy = 1'b0;
    q.push_back(e);
    cap = en && (!run || last);
    nst = !run ? (en ? 1 : 0) : en ? 1 : last ? 0 : 2;
    @(posedge clk); #1;
    if (run) begin
      if (last) m_fr = (m_fr + 1) % (1 << PW);
      if (m_h == HT - 1) m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      m_h = (m_h == HT - 1) ? 0 : m_h + 1;
    end
    if (cap) begin m_pat = int'(pat); m_col = col; end
    m_st = nst;
    it = q.pop_front();
    it.busy = m_st != 0;
  endtask

  task automatic test_reset();
    item_t it;
    repeat (3) begin
      @(posedge clk); #1;
      chk++;
      if (act() !== '0) $display("FAIL reset_hold got %h want 0", act()); else npass++;
    end
    rst = 1'b0;
    reset_model();
    repeat (3) begin
      tick(it); chk++;
      if (act() !== exp_of(it)) $display("FAIL reset_idle got %h want %h", act(), exp_of(it)); else npass++;
    end
  endtask

  task automatic test_ramp();
    item_t it;
    int first = -1, second = -1, nde = 0, nhs = 0, nvs = 0;
    logic phs = 1'b0;
    pat = 2'd0; en = 1'b1;
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      tick(it); chk++;
      if (act() !== exp_of(it)) $display("FAIL ramp h=%0d v=%0d got %h want %h", it.h, it.v, act(), exp_of(it)); else npass++;
      if (sof) begin if (first < 0) first = i; else if (second < 0) second = i; end
      if (first >= 0 && second < 0) begin nde += int'(de); nhs += int'(hs); nvs += int'(vs); end
      if (hs && !phs) begin
        chk++;
        if (it.h !== HA + HFP) $display("FAIL hs_start got h=%0d want %0d", it.h, HA + HFP); else npass++;
      end
      phs = hs;
    end
    chk++; if (first !== 1) $display("FAIL first_sof got %0d want 1", first); else npass++;
    chk++; if (second - first !== FRAME) $display("FAIL sof_period got %0d want %0d", second - first, FRAME); else npass++;
    chk++; if (nde !== HA * VA) $display("FAIL de_count got %0d want %0d", nde, HA * VA); else npass++;
    chk++; if (nhs !== HSW * VT) $display("FAIL hs_count got %0d want %0d", nhs, HSW * VT); else npass++;
    chk++; if (nvs !== HT * VSW) $display("FAIL vs_count got %0d want %0d", nvs, HT * VSW); else npass++;
  endtask

  task automatic test_bars();
    item_t it;
    int n = 0;
    logic [3*PW-1:0] want;
    pat = 2'd1;
    do begin
      tick(it); n++; chk++;
      if (act() !== exp_of(it)) $display("FAIL bars_pre got %h want %h", act(), exp_of(it)); else npass++;
    end while (!(m_h == 0 && m_v == 0) && n < 2 * FRAME);
    for (int i = 0; i < FRAME; i++) begin
      tick(it); chk++;
      if (act() !== exp_of(it)) $display("FAIL bars h=%0d v=%0d got %h want %h", it.h, it.v, act(), exp_of(it)); else npass++;
      if (it.de && it.v == 0 && (it.h < 4 || it.h >= 14)) begin
        want = it.h < 2 ? '1 : it.h < 4 ? {{PW{1'b0}}, {2 * PW{1'b1}}} : '0;
        chk++;
        if (dout !== want) $display("FAIL bar_pixel h=%0d got %h want %h", it.h, dout, want); else npass++;
      end
    end
  endtask

  task automatic test_solid();
    item_t it;
    int n = 0;
    logic [3*PW-1:0] c_old, c_new;
    c_old = {10'd1, 10'd2, 10'd3};
    c_new = {10'd4, 10'd5, 10'd6};
    pat = 2'd2; col = c_old;
    do begin
      tick(it); n++; chk++;
      if (act() !== exp_of(it)) $display("FAIL solid_pre got %h want %h", act(), exp_of(it)); else npass++;
    end while (!(m_h == 0 && m_v == 0) && n < 2 * FRAME);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i == 80) col = c_new;
      tick(it); chk++;
      if (act() !== exp_of(it)) $display("FAIL solid h=%0d v=%0d got %h want %h", it.h, it.v, act(), exp_of(it)); else npass++;
      if (it.de) begin
        chk++;
        if (dout !== (i < FRAME ? c_old : c_new)) $display("FAIL solid_color i=%0d got %h want %h", i, dout, i < FRAME ? c_old : c_new); else npass++;
      end
    end
  endtask

  task automatic test_stop();
    item_t it;
    int n = 0;
    en = 1'b0;
    repeat (3) begin
      tick(it); chk++;
      if (act() !== exp_of(it)) $display("FAIL stop_resume got %h want %h", act(), exp_of(it)); else npass++;
    end
    en = 1'b1;
    repeat (3) begin
      tick(it); chk++;
      if (act() !== exp_of(it)) $display("FAIL stop_resume got %h want %h", act(), exp_of(it)); else npass++;
    end
    chk++; if (busy !== 1'b1) $display("FAIL resume_busy got %b want 1", busy); else npass++;
    do begin
      tick(it); n++; chk++;
      if (act() !== exp_of(it)) $display("FAIL stop_align got %h want %h", act(), exp_of(it)); else npass++;
    end while (!(m_v == 1 && m_h == 4) && n < 2 * FRAME);
    en = 1'b0; n = 0;
    do begin
      tick(it); n++; chk++;
      if (act() !== exp_of(it)) $display("FAIL stop_drain h=%0d v=%0d got %h want %h", it.h, it.v, act(), exp_of(it)); else npass++;
    end while (busy && n < 2 * FRAME);
    chk++;
    if (busy !== 1'b0 || it.h !== HT - 1 || it.v !== VT - 1)
      $display("FAIL stop_last got busy=%b h=%0d v=%0d want busy=0 h=%0d v=%0d", busy, it.h, it.v, HT - 1, VT - 1);
    else npass++;
    repeat (3) begin
      tick(it); chk++;
      if (act() !== exp_of(it)) $display("FAIL stop_idle got %h want %h", act(), exp_of(it)); else npass++;
    end
    chk++; if ({dout, de, hs, vs, sof} !== '0) $display("FAIL idle_outputs got %h want 0", {dout, de, hs, vs, sof}); else npass++;
    en = 1'b1;
    tick(it); chk++;
    if (sof !== 1'b0) $display("FAIL restart_sof1 got %b want 0", sof); else npass++;
    tick(it); chk++;
    if (sof !== 1'b1 || it.h !== 0 || it.v !== 0) $display("FAIL restart_sof2 got sof=%b h=%0d v=%0d want 1 0 0", sof, it.h, it.v); else npass++;
  endtask

  task automatic test_rst_mid();
    item_t it;
    int n = 0;
    do begin
      tick(it); n++; chk++;
      if (act() !== exp_of(it)) $display("FAIL rst_align got %h want %h", act(), exp_of(it)); else npass++;
    end while (!(it.de && it.h == 5) && n < 2 * FRAME);
    #2 rst = 1'b1;
    #1 chk++;
    if (act() !== '0) $display("FAIL rst_async got %h want 0", act()); else npass++;
    en = 1'b0; pat = 2'd3; col = '0;
    repeat (2) @(posedge clk);
    #1 chk++;
    if (act() !== '0) $display("FAIL rst_held got %h want 0", act()); else npass++;
    rst = 1'b0;
    reset_model();
    repeat (3) begin
      tick(it); chk++;
      if (act() !== exp_of(it)) $display("FAIL rst_idle got %h want %h", act(), exp_of(it)); else npass++;
    end
    chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else npass++;
  endtask

  task automatic test_coord();
    item_t it;
    int k = -1;
    en = 1'b1;
    tick(it); chk++;
    if (act() !== exp_of(it)) $display("FAIL coord_start got %h want %h", act(), exp_of(it)); else npass++;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick(it); chk++;
      if (act() !== exp_of(it)) $display("FAIL coord h=%0d v=%0d got %h want %h", it.h, it.v, act(), exp_of(it)); else npass++;
      if (sof) begin
        k++; chk++;
        if (dout[3*PW-1:2*PW] !== PW'(k)) $display("FAIL coord_frame got %0d want %0d", dout[3*PW-1:2*PW], k); else npass++;
      end
      if (it.de && it.v == 2 && it.h == 5) begin
        chk++;
        if (dout[PW-1:0] !== 10'd5 || dout[2*PW-1:PW] !== 10'd2)
          $display("FAIL coord_rg got r=%0d g=%0d want r=5 g=2", dout[PW-1:0], dout[2*PW-1:PW]);
        else npass++;
      end
    end
    chk++; if (k !== 2) $display("FAIL coord_frames got %0d want 2", k); else npass++;
  endtask

  initial begin
    reset_model();
    test_reset();
    test_ramp();
    test_bars();
    test_solid();
    test_stop();
    test_rst_mid();
    test_coord();
    $display("%0d/%0d checks passed", npass, chk);
    $finish;
  end
endmodule
